// File: rtl/skel_pass_scheduler_pkg.sv
// skel_pass_scheduler_pkg: shared FSM states and default sizing for the thinning pass scheduler
package skel_pass_scheduler_pkg;

    localparam int DEF_N        = 8;
    localparam int DEF_MAX_ITER = 16;
    localparam int PIX_W        = 8;

    typedef enum logic [2:0] {
        LOAD,
        IDLE,
        SCAN,
        WAIT,
        COMMIT,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/skel_pass_scheduler_pixel_addr_counter.sv
// pixel_addr_counter: wrapping pixel address counter with clear, enable and terminal-count flag
module pixel_addr_counter #(
    parameter int W = 6,
    parameter logic [W-1:0] LAST = '1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         tc
);

    assign tc = cnt == LAST;

    // advance one address per enabled cycle, wrapping to 0 after LAST
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + 1'b1;

endmodule

// File: rtl/skel_pass_scheduler.sv
// skel_pass_scheduler: loads an image, then runs Zhang-Suen sub-iterations by scanning, marking and committing deletions
module skel_pass_scheduler
    import skel_pass_scheduler_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int bitSize  = $clog2(N*N),
    parameter int MAX_ITER = DEF_MAX_ITER
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [PIX_W-1:0]   data_in,
    input  logic               start,
    output logic               rd_en,
    output logic [bitSize-1:0] rd_addr,
    output logic               subiter,
    input  logic               mask_valid,
    input  logic               mask_del,
    output logic               wr_en,
    output logic [bitSize-1:0] wr_addr,
    output logic [PIX_W-1:0]   wr_data,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [7:0]         iter_count
);

    state_t               state, nstate;
    logic [bitSize-1:0]   cnt;
    logic                 tc, cnt_clr, cnt_en;
    logic [N*N-1:0]       mask;
    logic [bitSize:0]     chg;
    logic [7:0]           iter_nxt;
    logic                 launch;

    assign rd_addr  = cnt;
    assign iter_nxt = iter_count + 8'd1;
    assign launch   = start && (state == IDLE || state == DONE);

    pixel_addr_counter #(
        .W    (bitSize),
        .LAST (bitSize'(N*N-1))
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (cnt),
        .tc    (tc)
    );

    // next-state and address counter control
    always_comb begin
        nstate  = state;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        case (state)
            LOAD: begin
                cnt_en = we;
                nstate = (we && tc) ? IDLE : LOAD;
            end
            IDLE: begin
                cnt_clr = start;
                nstate  = start ? SCAN : IDLE;
            end
            SCAN:   nstate = WAIT;
            WAIT: begin
                cnt_en = mask_valid;
                nstate = !mask_valid ? WAIT : tc ? COMMIT : SCAN;
            end
            COMMIT: begin
                cnt_en = 1'b1;
                nstate = tc ? CHECK : COMMIT;
            end
            CHECK:  nstate = !subiter ? SCAN : (chg == '0 || iter_nxt == 8'(MAX_ITER)) ? DONE : SCAN;
            DONE: begin
                cnt_clr = start;
                nstate  = start ? SCAN : DONE;
            end
            default: nstate = LOAD;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= LOAD;
        else
            state <= nstate;

    // registered read/write ports and status flags
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_en   <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            rd_en   <= nstate == SCAN;
            wr_en   <= (state == LOAD && we) || (state == COMMIT && mask[cnt]);
            wr_addr <= cnt;
            wr_data <= state == LOAD ? data_in : '0;
            busy    <= nstate inside {SCAN, WAIT, COMMIT, CHECK};
            done    <= nstate == DONE;
        end

    // delete mask, change count and iteration bookkeeping
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mask       <= '0;
            chg        <= '0;
            iter_count <= '0;
            subiter    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            if (launch) begin
                mask       <= '0;
                chg        <= '0;
                iter_count <= '0;
                subiter    <= 1'b0;
                timeout    <= 1'b0;
            end
            if (state == WAIT && mask_valid && mask_del) begin
                mask[cnt] <= 1'b1;
                chg       <= &chg ? chg : chg + 1'b1;
            end
            if (state == COMMIT)
                mask[cnt] <= 1'b0;
            if (state == CHECK) begin
                if (!subiter)
                    subiter <= 1'b1;
                else begin
                    iter_count <= iter_nxt;
                    timeout    <= chg != '0 && iter_nxt == 8'(MAX_ITER);
                    if (nstate == SCAN) begin
                        subiter <= 1'b0;
                        chg     <= '0;
                    end
                end
            end
        end

endmodule
